regfile_ckpt: RTL and testbench

// Architectural x-register file with per-register rename state (busy bit + ROB tag) and N read ports.

---
 rtl/regfile_ckpt.sv | 199 +++++++++++++++++++
 tb/tb_regfile_ckpt.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ckpt.sv
// Architectural register file with per-register rename state (busy + producer tag)
// and a circular FIFO of rename-map checkpoints for branch-mispredict recovery.
module regfile_ckpt #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 5,
  parameter int NRD   = 2,
  parameter int NCKPT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          write_en,
  input  logic [$clog2(NREG)-1:0]       write_id,
  input  logic [TAG_W-1:0]              write_tag,
  input  logic [XLEN-1:0]               write_val,
  input  logic                          ren_en,
  input  logic [$clog2(NREG)-1:0]       ren_reg,
  input  logic [TAG_W-1:0]              ren_tag,
  input  logic [NRD*$clog2(NREG)-1:0]   query_id,
  output logic [NRD-1:0]                query_busy,
  output logic [NRD*TAG_W-1:0]          query_tag,
  output logic [NRD*XLEN-1:0]           query_val,
  input  logic                          ckpt_save,
  input  logic                          ckpt_release,
  input  logic                          ckpt_restore,
  input  logic [$clog2(NCKPT)-1:0]      ckpt_restore_id,
  output logic [$clog2(NCKPT)-1:0]      ckpt_alloc_id,
  output logic                          ckpt_full,
  output logic                          ckpt_empty
);

  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NCKPT);

  logic [XLEN-1:0]  r_val     [NREG];
  logic [NREG-1:0]  r_busy;
  logic [TAG_W-1:0] r_tag     [NREG];
  logic [NREG-1:0]  r_ck_busy [NCKPT];
  logic [TAG_W-1:0] r_ck_tag  [NCKPT][NREG];
  logic [CW-1:0]    r_head;
  logic [CW-1:0]    r_tail;
  logic [CW:0]      r_count;

  logic             w_commit;
  logic             w_ren;
  logic             w_full;
  logic             w_empty;
  logic             w_rel;
  logic             w_save;
  logic [NREG-1:0]  w_src_busy;
  logic [NREG-1:0]  w_busy_nxt;
  logic [TAG_W-1:0] w_src_tag [NREG];
  logic [TAG_W-1:0] w_tag_nxt [NREG];

  assign w_commit = write_en && (write_id != {RW{1'b0}});
  assign w_ren    = ren_en && (ren_reg != {RW{1'b0}}) && !ckpt_restore;
  assign w_full   = (r_count == (CW+1)'(NCKPT));
  assign w_empty  = (r_count == {(CW+1){1'b0}});
  assign w_rel    = ckpt_release && !ckpt_restore && !w_empty;
  // A release in the same cycle frees the slot a save into a full FIFO needs.
  assign w_save   = ckpt_save && !ckpt_restore && (!w_full || w_rel);

  assign ckpt_alloc_id = r_tail;
  assign ckpt_full     = w_full;
  assign ckpt_empty    = w_empty;

  always_comb begin
    w_src_busy = ckpt_restore ? r_ck_busy[ckpt_restore_id] : r_busy;
    for (int i = 0; i < NREG; i++) begin
      w_src_tag[i] = ckpt_restore ? r_ck_tag[ckpt_restore_id][i] : r_tag[i];
    end
  end

  // Post-update map: rename beats a same-cycle commit busy-clear.
  always_comb begin
    w_busy_nxt = w_src_busy;
    for (int i = 0; i < NREG; i++) begin
      w_tag_nxt[i] = w_src_tag[i];
      if (w_ren && (ren_reg == RW'(i))) begin
        w_busy_nxt[i] = 1'b1;
        w_tag_nxt[i]  = ren_tag;
      end else if (w_commit && (write_id == RW'(i)) && (w_src_tag[i] == write_tag)) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = w_src_busy[i];
      end
    end
    w_busy_nxt[0] = 1'b0;
    w_tag_nxt[0]  = {TAG_W{1'b0}};
  end

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_port
      logic [RW-1:0]    w_id;
      logic             w_b;
      logic [TAG_W-1:0] w_t;
      logic [XLEN-1:0]  w_v;

      assign w_id = query_id[g*RW +: RW];

      always_comb begin
        w_b = r_busy[w_id];
        w_t = r_tag[w_id];
        w_v = r_val[w_id];
        if (w_id == {RW{1'b0}}) begin
          w_b = 1'b0;
          w_t = {TAG_W{1'b0}};
          w_v = {XLEN{1'b0}};
        end else if (ren_en && (ren_reg == w_id)) begin
          w_b = 1'b1;
          w_t = ren_tag;
        end else if (write_en && (write_id == w_id) && r_busy[w_id] &&
                     (r_tag[w_id] == write_tag)) begin
          w_b = 1'b0;
          w_v = write_val;
        end else begin
          w_b = r_busy[w_id];
        end
      end

      assign query_busy[g]               = w_b;
      assign query_tag[g*TAG_W +: TAG_W] = w_t;
      assign query_val[g*XLEN +: XLEN]   = w_v;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= {XLEN{1'b0}};
        r_tag[i] <= {TAG_W{1'b0}};
      end
    end else if (flush) begin
      r_busy <= {NREG{1'b0}};
    end else begin
      if (w_commit) begin
        r_val[write_id] <= write_val;
      end
      r_busy <= w_busy_nxt;
      for (int i = 0; i < NREG; i++) begin
        r_tag[i] <= w_tag_nxt[i];
      end
    end
  end

  // Commits retire matching producers in every snapshot; a save then overwrites its slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NCKPT; s++) begin
        r_ck_busy[s] <= {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
          r_ck_tag[s][i] <= {TAG_W{1'b0}};
        end
      end
    end else if (!flush) begin
      for (int s = 0; s < NCKPT; s++) begin
        for (int i = 0; i < NREG; i++) begin
          if (w_commit && (write_id == RW'(i)) && (r_ck_tag[s][i] == write_tag)) begin
            r_ck_busy[s][i] <= 1'b0;
          end
        end
      end
      if (w_save) begin
        r_ck_busy[r_tail] <= w_busy_nxt;
        for (int i = 0; i < NREG; i++) begin
          r_ck_tag[r_tail][i] <= w_tag_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= {CW{1'b0}};
      r_tail  <= {CW{1'b0}};
      r_count <= {(CW+1){1'b0}};
    end else if (ckpt_restore) begin
      // The restored slot and everything younger are discarded.
      r_tail  <= ckpt_restore_id;
      r_count <= {1'b0, ckpt_restore_id - r_head};
    end else begin
      if (w_save) begin
        r_tail <= r_tail + CW'(1);
      end
      if (w_rel) begin
        r_head <= r_head + CW'(1);
      end
      if (w_save && !w_rel) begin
        r_count <= r_count + (CW+1)'(1);
      end else if (!w_save && w_rel) begin
        r_count <= r_count - (CW+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Self-checking bench for regfile_ckpt: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the register map and checkpoints.
module tb_regfile_ckpt;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 5;
  localparam int NRD   = 2;
  localparam int NCKPT = 4;
  localparam int RW    = 5;
  localparam int CW    = 2;

  logic                clk = 1'b0;
  logic                rst, flush, write_en, ren_en;
  logic [RW-1:0]       write_id, ren_reg;
  logic [TAG_W-1:0]    write_tag, ren_tag;
  logic [XLEN-1:0]     write_val;
  logic [NRD*RW-1:0]   query_id;
  logic [NRD-1:0]      query_busy;
  logic [NRD*TAG_W-1:0] query_tag;
  logic [NRD*XLEN-1:0] query_val;
  logic                ckpt_save, ckpt_release, ckpt_restore;
  logic [CW-1:0]       ckpt_restore_id, ckpt_alloc_id;
  logic                ckpt_full, ckpt_empty;

  always #5 clk = ~clk;

  regfile_ckpt #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NCKPT(NCKPT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_en(write_en), .write_id(write_id), .write_tag(write_tag), .write_val(write_val),
    .ren_en(ren_en), .ren_reg(ren_reg), .ren_tag(ren_tag),
    .query_id(query_id), .query_busy(query_busy), .query_tag(query_tag), .query_val(query_val),
    .ckpt_save(ckpt_save), .ckpt_release(ckpt_release), .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id), .ckpt_alloc_id(ckpt_alloc_id),
    .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty)
  );

  typedef struct packed {
    logic [NREG-1:0]            busy;
    logic [NREG-1:0][TAG_W-1:0] tag;
  } map_t;

  logic [XLEN-1:0] m_val [NREG];
  map_t            m_cur;
  map_t            m_q [$];
  int              m_head = 0;
  int              checks = 0;
  int              errors = 0;

  function automatic map_t apply_commit(input map_t m);
    map_t r = m;
    if (write_en && write_id != 0 && r.tag[write_id] == write_tag) r.busy[write_id] = 1'b0;
    return r;
  endfunction

  function automatic void m_step();
    map_t nm;
    int   idx;
    if (rst) begin
      foreach (m_val[i]) m_val[i] = '0;
      m_cur = '0;
      m_q.delete();
      m_head = 0;
    end else if (flush) begin
      m_cur.busy = '0;
      m_q.delete();
      m_head = 0;
    end else begin
      for (int i = 0; i < m_q.size(); i++) m_q[i] = apply_commit(m_q[i]);
      if (ckpt_restore) begin
        idx = (int'(ckpt_restore_id) - m_head + NCKPT) % NCKPT;
        nm = m_q[idx];
        while (m_q.size() > idx) void'(m_q.pop_back());
      end else begin
        nm = apply_commit(m_cur);
        if (ren_en && ren_reg != 0) begin
          nm.busy[ren_reg] = 1'b1;
          nm.tag[ren_reg]  = ren_tag;
        end
        if (ckpt_release && m_q.size() > 0) begin
          void'(m_q.pop_front());
          m_head = (m_head + 1) % NCKPT;
        end
        if (ckpt_save && m_q.size() < NCKPT) m_q.push_back(nm);
      end
      if (write_en && write_id != 0) m_val[write_id] = write_val;
      m_cur = nm;
    end
  endfunction

  function automatic void m_query(input int id, output logic b, output logic [TAG_W-1:0] t,
                                  output logic [XLEN-1:0] v);
    b = m_cur.busy[id];
    t = m_cur.tag[id];
    v = m_val[id];
    if (id == 0) begin
      b = 1'b0; t = '0; v = '0;
    end else if (ren_en && ren_reg == id) begin
      b = 1'b1; t = ren_tag;
    end else if (write_en && write_id == id && m_cur.busy[id] && m_cur.tag[id] == write_tag) begin
      b = 1'b0; v = write_val;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush = 1'b0; write_en = 1'b0; ren_en = 1'b0;
    write_id = '0; write_tag = '0; write_val = '0; ren_reg = '0; ren_tag = '0;
    ckpt_save = 1'b0; ckpt_release = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  task automatic rename(input int r, input int t);
    ren_en = 1'b1; ren_reg = RW'(r); ren_tag = TAG_W'(t);
  endtask

  task automatic commit(input int r, input int t, input logic [XLEN-1:0] v);
    write_en = 1'b1; write_id = RW'(r); write_tag = TAG_W'(t); write_val = v;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; query_id = '0;
    tick();
    idle(); query_id = {5'd0, 5'd5};
    #1;
    checks++;
    if (query_busy[0] !== 1'b0 || query_val[31:0] !== 32'h0)
      begin errors++; $display("FAIL reset_x5 busy=%0b val=%h expected busy=0 val=0", query_busy[0], query_val[31:0]); end
    checks++;
    if (query_busy[1] !== 1'b0 || query_tag[9:5] !== 5'd0 || query_val[63:32] !== 32'h0)
      begin errors++; $display("FAIL reset_x0 busy=%0b tag=%0d val=%h expected 0/0/0", query_busy[1], query_tag[9:5], query_val[63:32]); end
    checks++;
    if (ckpt_alloc_id !== 2'd0 || ckpt_full !== 1'b0 || ckpt_empty !== 1'b1)
      begin errors++; $display("FAIL reset_ckpt alloc=%0d full=%0b empty=%0b expected 0/0/1", ckpt_alloc_id, ckpt_full, ckpt_empty); end
  endtask

  task automatic test_commit();
    idle(); commit(5, 3, 32'h1234);
    tick();
    idle(); query_id = {5'd0, 5'd5};
    #1;
    checks++;
    if (query_val[31:0] !== 32'h1234 || query_busy[0] !== 1'b0)
      begin errors++; $display("FAIL commit_x5 val=%h busy=%0b expected val=1234 busy=0", query_val[31:0], query_busy[0]); end
  endtask

  task automatic test_bypass();
    idle(); rename(7, 9);
    tick();
    idle(); commit(7, 9, 32'hAA); query_id = {5'd0, 5'd7};
    #1;
    checks++;
    if (query_busy[0] !== 1'b0 || query_val[31:0] !== 32'hAA)
      begin errors++; $display("FAIL bypass_commit busy=%0b val=%h expected busy=0 val=aa", query_busy[0], query_val[31:0]); end
    tick();
    idle();
    #1;
    checks++;
    if (query_busy[0] !== 1'b0 || query_val[31:0] !== 32'hAA)
      begin errors++; $display("FAIL stored_commit busy=%0b val=%h expected busy=0 val=aa", query_busy[0], query_val[31:0]); end
    rename(7, 3); query_id = {5'd7, 5'd0};
    #1;
    checks++;
    if (query_busy[1] !== 1'b1 || query_tag[9:5] !== 5'd3)
      begin errors++; $display("FAIL bypass_rename busy=%0b tag=%0d expected busy=1 tag=3", query_busy[1], query_tag[9:5]); end
  endtask

  task automatic test_stale_commit();
    idle(); rename(7, 9); tick();
    idle(); rename(7, 12); tick();
    idle(); commit(7, 9, 32'd5); tick();
    idle(); query_id = {5'd0, 5'd7};
    #1;
    checks++;
    if (query_val[31:0] !== 32'd5 || query_busy[0] !== 1'b1 || query_tag[4:0] !== 5'd12)
      begin errors++; $display("FAIL stale_commit val=%0d busy=%0b tag=%0d expected 5/1/12", query_val[31:0], query_busy[0], query_tag[4:0]); end
  endtask

  task automatic test_restore();
    idle(); rename(3, 4); tick();
    idle(); ckpt_save = 1'b1; tick();
    idle(); rename(3, 6); tick();
    idle(); ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; tick();
    idle(); query_id = {5'd0, 5'd3};
    #1;
    checks++;
    if (query_busy[0] !== 1'b1 || query_tag[4:0] !== 5'd4)
      begin errors++; $display("FAIL restore_x3 busy=%0b tag=%0d expected busy=1 tag=4", query_busy[0], query_tag[4:0]); end
    checks++;
    if (ckpt_alloc_id !== 2'd0 || ckpt_empty !== 1'b1)
      begin errors++; $display("FAIL restore_ptr alloc=%0d empty=%0b expected 0/1", ckpt_alloc_id, ckpt_empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin idle(); ckpt_save = 1'b1; tick(); end
    idle();
    checks++;
    if (ckpt_full !== 1'b1 || ckpt_alloc_id !== 2'd0)
      begin errors++; $display("FAIL full_four full=%0b alloc=%0d expected 1/0", ckpt_full, ckpt_alloc_id); end
    ckpt_save = 1'b1; tick(); idle();
    checks++;
    if (ckpt_full !== 1'b1 || ckpt_alloc_id !== 2'd0)
      begin errors++; $display("FAIL save_when_full full=%0b alloc=%0d expected 1/0", ckpt_full, ckpt_alloc_id); end
    ckpt_release = 1'b1; tick(); idle();
    checks++;
    if (ckpt_full !== 1'b0 || ckpt_empty !== 1'b0)
      begin errors++; $display("FAIL release_one full=%0b empty=%0b expected 0/0", ckpt_full, ckpt_empty); end
    ckpt_save = 1'b1; ckpt_release = 1'b1; tick(); idle();
    checks++;
    if (ckpt_full !== 1'b0 || ckpt_alloc_id !== 2'd1)
      begin errors++; $display("FAIL save_release full=%0b alloc=%0d expected 0/1", ckpt_full, ckpt_alloc_id); end
    ckpt_release = 1'b1; tick(); tick(); idle();
    checks++;
    if (ckpt_empty !== 1'b0)
      begin errors++; $display("FAIL count_three_a empty=%0b expected 0", ckpt_empty); end
    ckpt_release = 1'b1; tick(); idle();
    checks++;
    if (ckpt_empty !== 1'b1)
      begin errors++; $display("FAIL count_three_b empty=%0b expected 1", ckpt_empty); end
    ckpt_release = 1'b1; tick(); idle();
    checks++;
    if (ckpt_empty !== 1'b1 || ckpt_alloc_id !== 2'd1)
      begin errors++; $display("FAIL release_empty empty=%0b alloc=%0d expected 1/1", ckpt_empty, ckpt_alloc_id); end
  endtask

  task automatic test_ckpt_commit();
    int rid;
    idle(); rename(8, 2); tick();
    rid = (m_head + m_q.size()) % NCKPT;
    idle(); ckpt_save = 1'b1; tick();
    idle(); commit(8, 2, 32'h55); tick();
    idle(); ckpt_restore = 1'b1; ckpt_restore_id = CW'(rid); tick();
    idle(); query_id = {5'd0, 5'd8};
    #1;
    checks++;
    if (query_busy[0] !== 1'b0 || query_val[31:0] !== 32'h55)
      begin errors++; $display("FAIL ckpt_commit busy=%0b val=%h expected busy=0 val=55", query_busy[0], query_val[31:0]); end
    checks++;
    if (ckpt_empty !== 1'b1 || ckpt_alloc_id !== CW'(rid))
      begin errors++; $display("FAIL ckpt_commit_ptr empty=%0b alloc=%0d expected 1/%0d", ckpt_empty, ckpt_alloc_id, rid); end
  endtask

  task automatic test_flush();
    idle(); rename(10, 1); ckpt_save = 1'b1; tick();
    idle(); rename(11, 2); tick();
    idle(); commit(12, 0, 32'hBEEF); tick();
    idle(); flush = 1'b1; tick();
    idle(); query_id = {5'd11, 5'd10};
    #1;
    checks++;
    if (query_busy !== 2'b00 || ckpt_empty !== 1'b1)
      begin errors++; $display("FAIL flush_busy busy=%b empty=%0b expected 00/1", query_busy, ckpt_empty); end
    query_id = {5'd5, 5'd12};
    #1;
    checks++;
    if (query_val[31:0] !== 32'hBEEF || query_val[63:32] !== 32'h1234)
      begin errors++; $display("FAIL flush_vals x12=%h x5=%h expected beef/1234", query_val[31:0], query_val[63:32]); end
    rst = 1'b1; tick(); idle();
    #1;
    checks++;
    if (query_val !== 64'h0)
      begin errors++; $display("FAIL reset_vals val=%h expected 0", query_val); end
  endtask

  task automatic test_random();
    logic             eb;
    logic [TAG_W-1:0] et;
    logic [XLEN-1:0]  ev;
    int               id;
    for (int c = 0; c < 1500; c++) begin
      idle();
      write_en = 1'($urandom % 2);
      id = int'($urandom % 8);
      write_id = RW'(id);
      write_tag = (m_cur.busy[id] && ($urandom % 4 != 0)) ? m_cur.tag[id] : TAG_W'($urandom % 8);
      write_val = $urandom;
      ren_en = ($urandom % 3 == 0);
      ren_reg = RW'($urandom % 8);
      ren_tag = TAG_W'($urandom % 8);
      ckpt_save = ($urandom % 4 == 0);
      ckpt_release = ($urandom % 5 == 0);
      ckpt_restore_id = CW'($urandom);
      if (m_q.size() > 0 && $urandom % 10 == 0) begin
        ckpt_restore = 1'b1;
        ckpt_restore_id = CW'((m_head + int'($urandom % m_q.size())) % NCKPT);
        ren_en = 1'b0;
      end
      flush = ($urandom % 150 == 0);
      rst = ($urandom % 400 == 0);
      query_id = {RW'($urandom % 8), RW'($urandom % 8)};
      #1;
      for (int k = 0; k < NRD; k++) begin
        m_query(int'(query_id[k*RW +: RW]), eb, et, ev);
        checks++;
        if (query_busy[k] !== eb || query_tag[k*TAG_W +: TAG_W] !== et || query_val[k*XLEN +: XLEN] !== ev) begin
          errors++;
          $display("FAIL rand_query cyc=%0d port=%0d id=%0d got %0b/%0d/%h expected %0b/%0d/%h", c, k,
                   query_id[k*RW +: RW], query_busy[k], query_tag[k*TAG_W +: TAG_W], query_val[k*XLEN +: XLEN], eb, et, ev);
        end
      end
      tick();
      checks++;
      if (ckpt_alloc_id !== CW'((m_head + m_q.size()) % NCKPT) || ckpt_full !== (m_q.size() == NCKPT) ||
          ckpt_empty !== (m_q.size() == 0)) begin
        errors++;
        $display("FAIL rand_ckpt cyc=%0d got alloc=%0d full=%0b empty=%0b expected alloc=%0d live=%0d", c,
                 ckpt_alloc_id, ckpt_full, ckpt_empty, (m_head + m_q.size()) % NCKPT, m_q.size());
      end
    end
  endtask

  initial begin
    idle();
    query_id = '0;
    test_reset();
    test_commit();
    test_bypass();
    test_stale_commit();
    test_restore();
    test_full();
    test_ckpt_commit();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
